mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative 32-bit multiply/divide engine that sits directly upstream of the
//   Hi/Lo register file.
//   Takes MULT/MULTU/DIV/DIVU/MADD/MSUB requests from the execute stage and
//   computes the result over multiple cycles with a Start/Busy/Done handshake.
//   Delivers the 64-bit result as Hi/Lo data plus exactly one of three one-cycle
//   strobes, WriteEn/Madd/Msub, that the register file consumes directly.
// PARAMETERS
//   WIDTH  32  operand width; the Hi and Lo result halves are each WIDTH bits
// PORTS
//   Clk          in   1      clock; all state changes on posedge
//   Rst          in   1      reset, asynchronous, active-high
//   Start        in   1      request; accepted only when Busy==0 and Op is legal
//   Op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB
//   A            in   WIDTH  multiplicand / dividend (rs)
//   B            in   WIDTH  multiplier / divisor (rt)
//   Busy         out  1      high while an operation is in flight (MUL/DIV/FIX)
//   Done         out  1      one-cycle pulse when the result is valid
//   WriteHiData  out  WIDTH  result high half: product[63:32] or remainder
//   WriteLoData  out  WIDTH  result low half: product[31:0] or quotient
//   WriteEn      out  1      one-cycle pulse with Done for MULT/MULTU/DIV/DIVU
//   Madd         out  1      one-cycle pulse with Done for MADD
//   Msub         out  1      one-cycle pulse with Done for MSUB
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; internal accumulators cleared.
//   Reset asserted mid-operation aborts the operation with no strobe.
//   FSM states:
//     IDLE -Start-> MUL | DIV
//     MUL -32 iter-> FIX
//     DIV -32 iter-> FIX
//     FIX -> DONE
//     DONE -> IDLE, or -> MUL/DIV if a new Start is accepted in DONE.
//   Accept: at the posedge where Start=1, Busy=0 and Op is legal (000..101).
//     Capture A, B and Op at that edge.
//     Illegal Op codes (110, 111) and Start while Busy=1 are ignored.
//   Signed ops: MULT, DIV, MADD, MSUB operate on |A| and |B|.
//     FIX applies the sign: negate the 64-bit product if sign(A)^sign(B).
//     For division, quotient sign = sign(A)^sign(B); remainder sign = sign(A).
//   Unsigned ops: MULTU, DIVU; the FIX cycle passes the result through unchanged.
//   MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator.
//   DIV: restoring division, one quotient bit per cycle; quotient truncates
//     toward zero.
//   Latency:
//     accept edge = cycle 0;
//     Done/strobe high during cycle 34 (32 iterations + FIX + DONE register).
//   Divide by zero (B==0, DIV or DIVU): iterations are skipped,
//     accept -> FIX -> DONE.
//     Strobe is high in cycle 2 with Hi=A, Lo=32'hFFFFFFFF.
//   Signed overflow 0x80000000 / -1: Lo=0x80000000, Hi=0; no exception.
//   WriteHiData/WriteLoData are registered, update only on entry to DONE, and
//     hold until the next result.
//   Exactly one of WriteEn/Madd/Msub pulses per accepted operation,
//     coincident with Done.
//   MADD/MSUB: output the signed 64-bit product; the register file performs
//     the accumulate/subtract.
//   Busy is low in IDLE and DONE, so back-to-back issue is possible: a Start in
//     the DONE cycle is accepted.
// TESTING
//   1. MULT A=FFFFFFFF, B=00000002 -> cycle 34: Done=WriteEn=1,
//      Hi=FFFFFFFF, Lo=FFFFFFFE.
//   2. MULTU A=FFFFFFFF, B=00000002 -> cycle 34: Hi=00000001, Lo=FFFFFFFE;
//      Madd=Msub=0.
//   3. DIV A=FFFFFFF9 (-7), B=00000002 -> cycle 34: Lo=FFFFFFFD (-3),
//      Hi=FFFFFFFF (-1), WriteEn=1.
//   4. DIVU A=00000007, B=0 -> cycle 2: Done=1, Hi=00000007, Lo=FFFFFFFF.
//   5. MADD A=3, B=4, then MSUB A=3, B=4 issued in the DONE cycle ->
//      Madd pulse with Lo=0000000C, Hi=0; Msub pulse 34 cycles later.
//   6. MULT started, Rst pulsed at cycle 10, Start re-pulsed at cycle 5 ->
//      no strobe; Busy=0 after reset; outputs all 0; the cycle-5 Start ignored.

Source files
------------

// File: rtl/mult_div_if.sv
// Request/result bundle between the execute stage and the iterative
// multiply/divide engine feeding the Hi/Lo register file.
interface mult_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] WriteHiData;
  logic [WIDTH-1:0] WriteLoData;
  logic             WriteEn;
  logic             Madd;
  logic             Msub;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, WriteHiData, WriteLoData, WriteEn, Madd, Msub
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, WriteHiData, WriteLoData, WriteEn, Madd, Msub
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider producing Hi/Lo results
// with a one-cycle WriteEn/Madd/Msub strobe for the Hi/Lo register file.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic Clk,
  input  logic Rst,
  mult_div_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [2:0]       op_q;
  logic             is_div_q;
  logic             res_neg_q;
  logic             rem_neg_q;

  logic             accept_c;
  logic             req_div_c;
  logic             req_signed_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   rem_shift_c;
  logic [WIDTH:0]   div_diff_c;
  logic [ACC_W-1:0] mul_next_c;
  logic [ACC_W-1:0] div_next_c;
  logic [WIDTH-1:0] fix_hi_c;
  logic [WIDTH-1:0] fix_lo_c;

  // Request decode and operand magnitudes
  always_comb begin
    accept_c     = bus.Start && ((state == S_IDLE) || (state == S_DONE)) &&
                   (bus.Op <= OP_MSUB);
    req_div_c    = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
    req_signed_c = (bus.Op != OP_MULTU) && (bus.Op != OP_DIVU);
    a_neg_c      = req_signed_c && bus.A[WIDTH-1];
    b_neg_c      = req_signed_c && bus.B[WIDTH-1];
    a_mag_c      = a_neg_c ? -bus.A : bus.A;
    b_mag_c      = b_neg_c ? -bus.B : bus.B;
  end

  // One iteration step: acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum_c   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next_c  = {mul_sum_c, acc[WIDTH-1:1]};
    rem_shift_c = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
    div_diff_c  = rem_shift_c - {1'b0, opnd};
    div_next_c  = div_diff_c[WIDTH] ?
                  {rem_shift_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                  {div_diff_c[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction; sign flags are cleared for unsigned ops and divide-by-zero
  always_comb begin
    fix_hi_c = acc[ACC_W-1:WIDTH];
    fix_lo_c = acc[WIDTH-1:0];
    if (is_div_q) begin
      if (res_neg_q) fix_lo_c = -acc[WIDTH-1:0];
      if (rem_neg_q) fix_hi_c = -acc[ACC_W-1:WIDTH];
    end else if (res_neg_q) begin
      {fix_hi_c, fix_lo_c} = -acc;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      acc             <= '0;
      opnd            <= '0;
      op_q            <= '0;
      is_div_q        <= 1'b0;
      res_neg_q       <= 1'b0;
      rem_neg_q       <= 1'b0;
      bus.Busy        <= 1'b0;
      bus.Done        <= 1'b0;
      bus.WriteHiData <= '0;
      bus.WriteLoData <= '0;
      bus.WriteEn     <= 1'b0;
      bus.Madd        <= 1'b0;
      bus.Msub        <= 1'b0;
    end else begin
      bus.Done    <= 1'b0;
      bus.WriteEn <= 1'b0;
      bus.Madd    <= 1'b0;
      bus.Msub    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept_c) begin
            op_q      <= bus.Op;
            is_div_q  <= req_div_c;
            bus.Busy  <= 1'b1;
            cnt       <= '0;
            res_neg_q <= a_neg_c ^ b_neg_c;
            rem_neg_q <= a_neg_c;
            if (req_div_c) begin
              state <= S_DIV;
              opnd  <= b_mag_c;
              acc   <= {{WIDTH{1'b0}}, a_mag_c};
              // Divide by zero skips iterations and reports Hi=A, Lo=all ones
              if (bus.B == '0) begin
                cnt       <= CNT_W'(WIDTH);
                acc       <= {bus.A, {WIDTH{1'b1}}};
                res_neg_q <= 1'b0;
                rem_neg_q <= 1'b0;
              end
            end else begin
              state <= S_MUL;
              opnd  <= a_mag_c;
              acc   <= {{WIDTH{1'b0}}, b_mag_c};
            end
          end
        end
        S_MUL: begin
          if (cnt == CNT_W'(WIDTH)) begin
            state <= S_FIX;
          end else begin
            acc <= mul_next_c;
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (cnt == CNT_W'(WIDTH)) begin
            state <= S_FIX;
          end else begin
            acc <= div_next_c;
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          state           <= S_DONE;
          bus.Busy        <= 1'b0;
          bus.Done        <= 1'b1;
          bus.WriteHiData <= fix_hi_c;
          bus.WriteLoData <= fix_lo_c;
          bus.WriteEn     <= (op_q != OP_MADD) && (op_q != OP_MSUB);
          bus.Madd        <= (op_q == OP_MADD);
          bus.Msub        <= (op_q == OP_MSUB);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, strobes, signs,
// divide-by-zero, overflow, back-to-back issue and reset abort.
module tb_mult_div_unit;

  localparam int unsigned WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

  localparam logic [2:0] STB_WE   = 3'b100;
  localparam logic [2:0] STB_MADD = 3'b010;
  localparam logic [2:0] STB_MSUB = 3'b001;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  mult_div_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] hi,
                        input logic [31:0] lo, input logic [2:0] stb);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    check({tag, "_busy0"}, 64'(bus.Busy), 64'd1);
    repeat (lat - 1) @(negedge Clk);
    check({tag, "_early"}, 64'(bus.Done), 64'd0);
    @(negedge Clk);
    check({tag, "_stb"}, 64'({bus.Done, bus.WriteEn, bus.Madd, bus.Msub}), 64'({1'b1, stb}));
    check({tag, "_data"}, {bus.WriteHiData, bus.WriteLoData}, {hi, lo});
    check({tag, "_busyd"}, 64'(bus.Busy), 64'd0);
  endtask

  // Result must hold and strobes drop in the cycle after DONE
  task automatic check_hold(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    @(negedge Clk);
    check({tag, "_hold"}, {bus.WriteHiData, bus.WriteLoData}, {hi, lo});
    check({tag, "_drop"}, 64'({bus.Done, bus.WriteEn, bus.Madd, bus.Msub}), 64'd0);
  endtask

  initial begin
    logic seen;
    checks    = 0;
    errors    = 0;
    Rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge Clk);
    check("reset_ctl", 64'({bus.Busy, bus.Done, bus.WriteEn, bus.Madd, bus.Msub}), 64'd0);
    check("reset_data", {bus.WriteHiData, bus.WriteLoData}, 64'd0);
    Rst = 1'b0;
    @(negedge Clk);

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFF, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFE, STB_WE);
    check_hold("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 34, 32'h00000001, 32'hFFFFFFFE, STB_WE);
    check_hold("multu", 32'h00000001, 32'hFFFFFFFE);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, STB_WE);
    check_hold("multu_max", 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_nn", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFC, 34, 32'h00000000, 32'h0000000C, STB_WE);
    check_hold("mult_nn", 32'h00000000, 32'h0000000C);
    run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, STB_WE);
    check_hold("mult_min", 32'h40000000, 32'h00000000);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, STB_WE);
    check_hold("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, STB_WE);
    check_hold("div_negb", 32'h00000001, 32'hFFFFFFFD);
    run_op("divu", OP_DIVU, 32'h00000064, 32'h00000007, 34, 32'h00000002, 32'h0000000E, STB_WE);
    check_hold("divu", 32'h00000002, 32'h0000000E);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, STB_WE);
    check_hold("div_ovf", 32'h00000000, 32'h80000000);
    run_op("divu_z", OP_DIVU, 32'h00000007, 32'h00000000, 2, 32'h00000007, 32'hFFFFFFFF, STB_WE);
    check_hold("divu_z", 32'h00000007, 32'hFFFFFFFF);
    run_op("div_z", OP_DIV, 32'hFFFFFFF9, 32'h00000000, 2, 32'hFFFFFFF9, 32'hFFFFFFFF, STB_WE);
    check_hold("div_z", 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Illegal opcode is ignored
    bus.Start = 1'b1;
    bus.Op    = 3'b110;
    bus.A     = 32'h5;
    bus.B     = 32'h5;
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    check("illegal_busy", 64'(bus.Busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      seen = seen | bus.Done | bus.Busy;
    end
    check("illegal_quiet", 64'(seen), 64'd0);

    // MADD then MSUB issued in the DONE cycle
    run_op("madd", OP_MADD, 32'h00000003, 32'h00000004, 34, 32'h00000000, 32'h0000000C, STB_MADD);
    run_op("msub_b2b", OP_MSUB, 32'h00000003, 32'h00000004, 34, 32'h00000000, 32'h0000000C, STB_MSUB);
    run_op("msub_neg", OP_MSUB, 32'h00000005, 32'hFFFFFFFE, 34, 32'hFFFFFFFF, 32'hFFFFFFF6, STB_MSUB);
    check_hold("msub_neg", 32'hFFFFFFFF, 32'hFFFFFFF6);

    // Start while busy is ignored; reset mid-operation aborts without a strobe
    bus.Start = 1'b1;
    bus.Op    = OP_MULT;
    bus.A     = 32'h00000005;
    bus.B     = 32'h00000005;
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (5) @(negedge Clk);
    check("abort_busy5", 64'(bus.Busy), 64'd1);
    bus.Start = 1'b1;
    bus.Op    = OP_MULTU;
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (4) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("abort_ctl", 64'({bus.Busy, bus.Done, bus.WriteEn, bus.Madd, bus.Msub}), 64'd0);
    check("abort_data", {bus.WriteHiData, bus.WriteLoData}, 64'd0);
    @(negedge Clk);
    Rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      seen = seen | bus.Done | bus.Busy | bus.WriteEn | bus.Madd | bus.Msub;
    end
    check("abort_quiet", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
